addsub_seq: RTL and testbench
=============================

# addsub_seq

Parametrised, segment-serial adder/subtractor with valid/ready handshakes on input and output. It supports four operations: add, subtract, negate and add-with-carry. It produces the result plus carry, signed-overflow, zero and negative flags. It is the next generation of the ALU arithmetic path, replacing fixed 32-bit combinational add/negate with a width-generic unit. That unit trades latency for a short carry chain of SEG bits per cycle.

## Interface
- WIDTH, 32: operand/result width; must be a multiple of SEG.
- SEG, 8: bits processed per cycle; NSEG = WIDTH/SEG, NSEG ≥ 1.
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- op  input  2  00 add, 01 sub (A−B), 10 negate (0−B, A ignored), 11 add with carry (A+B+cin).
- cin  input  1  carry-in, used only for op 11.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- co  output  1  carry out of MSB; for sub/negate, 1 = no borrow.
- ovf  output  1  two's-complement overflow.
- zero  output  1  sum == 0.
- neg  output  1  sum[WIDTH-1].

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- in_ready = (state==IDLE) && rst_n; it is 0 while reset is asserted.
- **Accept (IDLE, in_valid & in_ready).** On the accepting edge, latch the operands as follows:
  - opA = (op==10) ? 0 : a.
  - opB = (op==01 || op==10) ? ~b : b.
  - carry = 1 for sub/negate, cin for op 11, 0 for add.
  - Clear the segment index; the FSM goes to RUN.
- **RUN.** Each cycle, add segment k of opA and opB plus carry:
  - Write the SEG-bit result into the result register at slice k.
  - Update carry.
  - When k = NSEG−1, also record the carry into the MSB.
  - After segment NSEG−1, go to DONE.
- **DONE.** out_valid = 1. sum and flags are registered and stable while out_valid is high.
  - On out_valid & out_ready, go to IDLE.
- **Flags:**
  - co = final carry.
  - ovf = carry into MSB XOR carry out of MSB.
  - zero and neg are computed from the full result.
- Negate of the most negative value (1 followed by zeros) returns the same value with ovf = 1. Negate of 0 returns 0 with co = 1.
- in_valid while not IDLE is ignored; there is no queuing.
- Inputs a, b, op and cin are sampled only on the accepting edge; later changes have no effect.
- After the output handshake, sum and flags retain their last values and out_valid = 0.
- **Reset, asynchronous at any time, including mid-RUN:**
  - state = IDLE.
  - out_valid = 0.
  - sum = 0; co, ovf, zero, neg = 0.
  - Segment index = 0, internal carry = 0.
  - Any in-flight operation is discarded with no partial output.

## Timing
- Latency: accept on edge t, out_valid high after edge t+NSEG.
- in_ready returns to 1 the cycle after the output handshake edge.
- Throughput: at most one result per NSEG+2 cycles with out_ready held at 1.
- Combinational depth: one SEG-bit carry chain plus the operand mux. No combinational path from in_valid or out_ready to any output except through state.

## Structure
- Shared package addsub_pkg holds:
  - the op_e enum: OP_ADD, OP_SUB, OP_NEG, OP_ADC;
  - the state_e enum: IDLE, RUN, DONE.
- One sub-module, addsub_slice: SEG-bit combinational adder with inputs x, y, ci and outputs s, co, c_msb (carry into its MSB).
- Top level holds the FSM, segment counter ($clog2(NSEG) bits, minimum 1), operand shift/indexing and flag logic.
- Elaboration-time check that WIDTH % SEG == 0.

## Test plan
- Default params, add 0xFFFFFFFF + 0x00000001 → sum 0x00000000, co 1, ovf 0, zero 1, neg 0; out_valid exactly 4 cycles after accept.
- Sub 0x00000005 − 0x00000007 → sum 0xFFFFFFFE, co 0, ovf 0, neg 1. Add 0x7FFFFFFF + 1 → 0x80000000, ovf 1, co 0.
- Negate b = 0x80000000 → 0x80000000, ovf 1. Negate b = 0 → 0, co 1, zero 1. ADC 0xFFFFFFFF + 0 + cin 1 → 0, co 1.
- Backpressure: hold out_ready = 0 for 10 cycles in DONE → sum and flags stable, in_ready 0, in_valid pulses ignored. Release → next request accepted the cycle after the handshake.
- Reset pulse mid-RUN (after segment 1) → out_valid 0, sum 0 immediately. First request after reset (3 + 4 = 7) completes with correct latency.
- WIDTH=16, SEG=4: 0x8000 − 0x0001 → 0x7FFF, ovf 1, co 1, latency 4. WIDTH=8, SEG=8: latency 1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared types for the segment-serial adder/subtractor.
//   op_e    : operation encoding seen on the op port
//   state_e : sequencing FSM states
//   seg_idx_w() : width of the segment counter (never below 1 bit)
package addsub_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_NEG = 2'b10,
    OP_ADC = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_e;

  function automatic int seg_idx_w(input int nseg);
    return (nseg > 1) ? $clog2(nseg) : 1;
  endfunction

endpackage

// File: rtl/addsub_slice.sv
// One SEG-bit slice of the ripple adder, purely combinational.
//   x, y  : slice operands
//   ci    : carry into bit 0 of the slice
//   s     : slice sum
//   co    : carry out of the slice MSB
//   c_msb : carry into the slice MSB (used for signed overflow)
module addsub_slice
  import addsub_pkg::*;
#(
  parameter int SEG = 8
) (
  input  logic [SEG-1:0] x,
  input  logic [SEG-1:0] y,
  input  logic           ci,
  output logic [SEG-1:0] s,
  output logic           co,
  output logic           c_msb
);

  logic [SEG:0] full;

  assign full = {1'b0, x} + {1'b0, y} + {{SEG{1'b0}}, ci};
  assign s    = full[SEG-1:0];
  assign co   = full[SEG];
  // sum bit = x ^ y ^ carry-in, so the carry into the MSB falls out of the XOR.
  assign c_msb = s[SEG-1] ^ x[SEG-1] ^ y[SEG-1];

endmodule

// File: rtl/addsub_seq.sv
// Segment-serial adder/subtractor with valid/ready handshakes.
// Processes SEG bits per cycle, so a request takes WIDTH/SEG cycles in RUN.
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid / in_ready : request handshake (a, b, op, cin sampled on accept)
//   out_valid/out_ready : result handshake
//   sum, co, ovf, zero, neg : registered result and flags
module addsub_seq
  import addsub_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SEG   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       op,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             co,
  output logic             ovf,
  output logic             zero,
  output logic             neg
);

  localparam int NSEG = WIDTH / SEG;
  localparam int IDXW = seg_idx_w(NSEG);
  localparam logic [WIDTH-1:0] SEG_MASK = WIDTH'({SEG{1'b1}});

  if ((WIDTH % SEG) != 0 || WIDTH < SEG) begin : g_width_check
    $error("addsub_seq: WIDTH must be a non-zero multiple of SEG");
  end

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d, opb_q, opb_d, res_q, res_d;
  logic             carry_q, carry_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             co_q, co_d, ovf_q, ovf_d, zero_q, zero_d, neg_q, neg_d;

  op_e              op_in;
  logic             accept, last_seg;
  logic [31:0]      shamt;
  logic [SEG-1:0]   seg_x, seg_y, seg_s;
  logic             seg_co, seg_cmsb;

  assign op_in    = op_e'(op);
  assign accept   = in_valid && in_ready;
  assign last_seg = (idx_q == IDXW'(NSEG - 1));
  assign shamt    = 32'(idx_q) * 32'(SEG);
  assign seg_x    = SEG'(opa_q >> shamt);
  assign seg_y    = SEG'(opb_q >> shamt);

  addsub_slice #(.SEG(SEG)) u_slice (
    .x     (seg_x),
    .y     (seg_y),
    .ci    (carry_q),
    .s     (seg_s),
    .co    (seg_co),
    .c_msb (seg_cmsb)
  );

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept)    state_d = RUN;
      RUN:     if (last_seg)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  // Handshake outputs depend only on state (and reset for in_ready)
  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);
  end

  // Operand capture and per-segment datapath
  always_comb begin
    opa_d   = opa_q;
    opb_d   = opb_q;
    carry_d = carry_q;
    idx_d   = idx_q;
    res_d   = res_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    zero_d  = zero_q;
    neg_d   = neg_q;
    if (accept) begin
      // Subtraction is A + ~B + 1; negate is the same with A forced to 0.
      opa_d   = (op_in == OP_NEG) ? '0 : a;
      opb_d   = (op_in == OP_SUB || op_in == OP_NEG) ? ~b : b;
      carry_d = (op_in == OP_SUB || op_in == OP_NEG) ? 1'b1
              : (op_in == OP_ADC) ? cin : 1'b0;
      idx_d   = '0;
    end else if (state_q == RUN) begin
      res_d   = (res_q & ~(SEG_MASK << shamt)) | (WIDTH'(seg_s) << shamt);
      carry_d = seg_co;
      idx_d   = idx_q + IDXW'(1);
      if (last_seg) begin
        co_d   = seg_co;
        ovf_d  = seg_cmsb ^ seg_co;
        zero_d = (res_d == '0);
        neg_d  = res_d[WIDTH-1];
        idx_d  = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_q   <= '0;
      opb_q   <= '0;
      carry_q <= 1'b0;
      idx_q   <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
      zero_q  <= 1'b0;
      neg_q   <= 1'b0;
    end else begin
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      carry_q <= carry_d;
      idx_q   <= idx_d;
      res_q   <= res_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
      zero_q  <= zero_d;
      neg_q   <= neg_d;
    end
  end

  assign sum  = res_q;
  assign co   = co_q;
  assign ovf  = ovf_q;
  assign zero = zero_q;
  assign neg  = neg_q;

endmodule

// File: tb/tb_addsub_seq.sv
// Self-checking bench for addsub_seq: default 32/8 instance plus 16/4 and 8/8 instances.
module tb_addsub_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b1;

  logic        in_valid = 0, in_ready, cin = 0, out_valid, out_ready = 0;
  logic [31:0] a = 0, b = 0, sum;
  logic [1:0]  op = 0;
  logic        co, ovf, zero, neg;

  logic        p16_in_valid = 0, p16_in_ready, p16_cin = 0, p16_out_valid, p16_out_ready = 0;
  logic [15:0] p16_a = 0, p16_b = 0, p16_sum;
  logic [1:0]  p16_op = 0;
  logic        p16_co, p16_ovf, p16_zero, p16_neg;

  logic        p8_in_valid = 0, p8_in_ready, p8_cin = 0, p8_out_valid, p8_out_ready = 0;
  logic [7:0]  p8_a = 0, p8_b = 0, p8_sum;
  logic [1:0]  p8_op = 0;
  logic        p8_co, p8_ovf, p8_zero, p8_neg;

  addsub_seq dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .op(op), .cin(cin), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .co(co), .ovf(ovf), .zero(zero), .neg(neg));

  addsub_seq #(.WIDTH(16), .SEG(4)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(p16_in_valid), .in_ready(p16_in_ready),
    .a(p16_a), .b(p16_b), .op(p16_op), .cin(p16_cin), .out_valid(p16_out_valid),
    .out_ready(p16_out_ready), .sum(p16_sum), .co(p16_co), .ovf(p16_ovf),
    .zero(p16_zero), .neg(p16_neg));

  addsub_seq #(.WIDTH(8), .SEG(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(p8_in_valid), .in_ready(p8_in_ready),
    .a(p8_a), .b(p8_b), .op(p8_op), .cin(p8_cin), .out_valid(p8_out_valid),
    .out_ready(p8_out_ready), .sum(p8_sum), .co(p8_co), .ovf(p8_ovf),
    .zero(p8_zero), .neg(p8_neg));

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [31:0] sum;
    logic        co;
    logic        ovf;
    logic        zero;
    logic        neg;
  } res_t;

  // Reference: plain integer arithmetic on w-bit values, overflow from operand/result signs.
  function automatic res_t model(input int w, input logic [31:0] ia, input logic [31:0] ib,
                                 input logic [1:0] iop, input logic icin);
    longint unsigned mask, av, bv, full;
    logic sa, sb, sr;
    res_t r;
    mask = (64'd1 << w) - 64'd1;
    av   = (iop == 2'b10) ? 64'd0 : ({32'd0, ia} & mask);
    bv   = {32'd0, ib} & mask;
    if (iop == 2'b00 || iop == 2'b11) begin
      full = av + bv + ((iop == 2'b11) ? {63'd0, icin} : 64'd0);
      r.co = ((full >> w) & 64'd1) != 0;
    end else begin
      full = (av - bv) & mask;
      r.co = (av >= bv);
    end
    full  = full & mask;
    r.sum = full[31:0];
    sa = av[w-1];
    sb = bv[w-1];
    sr = full[w-1];
    if (iop == 2'b00 || iop == 2'b11) r.ovf = (sa == sb) && (sr != sa);
    else                              r.ovf = (sa != sb) && (sr != sa);
    r.zero = (full == 0);
    r.neg  = sr;
    return r;
  endfunction

  function automatic res_t got32();
    return {sum, co, ovf, zero, neg};
  endfunction

  logic [31:0] dir_a  [6] = '{32'hFFFFFFFF, 32'h00000005, 32'h7FFFFFFF, 32'h12345678, 32'hFFFFFFFF, 32'hFFFFFFFF};
  logic [31:0] dir_b  [6] = '{32'h00000001, 32'h00000007, 32'h00000001, 32'h80000000, 32'h00000000, 32'h00000000};
  logic [1:0]  dir_op [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b10, 2'b11};
  logic        dir_ci [6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1};

  // Drive one request on the default instance and count edges until out_valid.
  task automatic issue(input logic [31:0] ia, input logic [31:0] ib, input logic [1:0] iop,
                       input logic icin, output int lat);
    @(negedge clk);
    a = ia; b = ib; op = iop; cin = icin; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = $urandom; b = $urandom; op = 2'($urandom); cin = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    @(negedge clk);
    out_ready = 1'b1; p16_out_ready = 1'b1; p8_out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0; p16_out_ready = 1'b0; p8_out_ready = 1'b0;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 5))
      0: return 32'h00000000;
      1: return 32'hFFFFFFFF;
      2: return 32'h80000000;
      3: return 32'h7FFFFFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #11;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b want=0", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++;
    if (got32() !== '0) begin errors++; $display("FAIL reset_result got=%h want=0", got32()); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL idle_in_ready got=%b want=1", in_ready); end
  endtask

  task automatic test_directed();
    int lat;
    res_t exp;
    for (int i = 0; i < 6; i++) begin
      exp = model(32, dir_a[i], dir_b[i], dir_op[i], dir_ci[i]);
      issue(dir_a[i], dir_b[i], dir_op[i], dir_ci[i], lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL dir%0d_latency got=%0d want=4", i, lat); end
      checks++;
      if (got32() !== exp) begin errors++; $display("FAIL dir%0d_result got=%h want=%h", i, got32(), exp); end
      handshake();
      checks++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
        errors++; $display("FAIL dir%0d_post_hs got ov=%b ir=%b want ov=0 ir=1", i, out_valid, in_ready);
      end
      checks++;
      if (got32() !== exp) begin errors++; $display("FAIL dir%0d_retain got=%h want=%h", i, got32(), exp); end
    end
  endtask

  task automatic test_random();
    int lat;
    res_t exp;
    logic [31:0] ra, rb;
    logic [1:0] rop;
    logic rc;
    for (int i = 0; i < 40; i++) begin
      ra = pick_val(); rb = pick_val(); rop = 2'($urandom); rc = 1'($urandom);
      exp = model(32, ra, rb, rop, rc);
      issue(ra, rb, rop, rc, lat);
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL rnd%0d_latency got=%0d want=4", i, lat); end
      checks++;
      if (got32() !== exp) begin
        errors++; $display("FAIL rnd%0d_result a=%h b=%h op=%0d got=%h want=%h", i, ra, rb, rop, got32(), exp);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    res_t exp, exp2;
    logic [31:0] na, nb;
    exp = model(32, 32'h89ABCDEF, 32'h1234F00D, 2'b01, 1'b0);
    issue(32'h89ABCDEF, 32'h1234F00D, 2'b01, 1'b0, lat);
    checks++;
    if (got32() !== exp) begin errors++; $display("FAIL bp_result got=%h want=%h", got32(), exp); end
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      in_valid = ~in_valid; a = $urandom; b = $urandom; op = 2'($urandom);
      @(posedge clk); #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 || got32() !== exp) begin
        errors++;
        $display("FAIL bp_hold%0d got ov=%b ir=%b res=%h want ov=1 ir=0 res=%h", i, out_valid, in_ready, got32(), exp);
      end
    end
    na = $urandom; nb = $urandom;
    exp2 = model(32, na, nb, 2'b00, 1'b0);
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; a = na; b = nb; op = 2'b00; cin = 1'b0;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got ov=%b ir=%b want ov=0 ir=1", out_valid, in_ready);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL bp_next_accept got ir=%b want 0", in_ready); end
    lat = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL bp_next_latency got=%0d want=4", lat); end
    checks++;
    if (got32() !== exp2) begin errors++; $display("FAIL bp_next_result got=%h want=%h", got32(), exp2); end
    handshake();
  endtask

  task automatic test_reset_mid_run();
    int lat;
    res_t exp;
    @(negedge clk);
    a = 32'h12345678; b = 32'h11111111; op = 2'b00; cin = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0 || got32() !== '0) begin
      errors++; $display("FAIL rst_mid got ov=%b ir=%b res=%h want 0 0 0", out_valid, in_ready, got32());
    end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1 || got32() !== '0) begin
      errors++; $display("FAIL rst_release got ir=%b res=%h want ir=1 res=0", in_ready, got32());
    end
    exp = model(32, 32'd3, 32'd4, 2'b00, 1'b0);
    issue(32'd3, 32'd4, 2'b00, 1'b0, lat);
    checks++;
    if (lat !== 4) begin errors++; $display("FAIL rst_first_latency got=%0d want=4", lat); end
    checks++;
    if (got32() !== exp || sum !== 32'd7) begin errors++; $display("FAIL rst_first_result got=%h want=%h", got32(), exp); end
    handshake();
  endtask

  task automatic test_back_to_back();
    res_t q[$];
    res_t exp;
    int times[$];
    int cyc = 0;
    int bound = 0;
    logic [31:0] ra, rb;
    logic [1:0] rop;
    logic rc;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ra = $urandom; rb = $urandom; rop = 2'($urandom); rc = 1'($urandom);
        a = ra; b = rb; op = rop; cin = rc;
        q.push_back(model(32, ra, rb, rop, rc));
      end
      @(posedge clk); #1;
      cyc++;
      if (out_valid) begin
        times.push_back(cyc);
        exp = q.pop_front();
        checks++;
        if (got32() !== exp) begin errors++; $display("FAIL b2b_result got=%h want=%h", got32(), exp); end
      end
    end
    in_valid = 1'b0;
    while (q.size() > 0 && bound < 20) begin
      @(posedge clk); #1;
      cyc++; bound++;
      if (out_valid) begin
        times.push_back(cyc);
        exp = q.pop_front();
        checks++;
        if (got32() !== exp) begin errors++; $display("FAIL b2b_drain_result got=%h want=%h", got32(), exp); end
      end
    end
    out_ready = 1'b0;
    checks++;
    if (q.size() != 0 || times.size() < 5) begin
      errors++; $display("FAIL b2b_count got left=%0d done=%0d want left=0 done>=5", q.size(), times.size());
    end
    for (int i = 1; i < times.size(); i++) begin
      checks++;
      if (times[i] - times[i-1] != 6) begin
        errors++; $display("FAIL b2b_interval%0d got=%0d want=6", i, times[i] - times[i-1]);
      end
    end
  endtask

  task automatic test_params();
    int lat;
    res_t exp, got;
    logic [31:0] ra, rb;
    logic [1:0] rop;
    logic rc;
    for (int i = 0; i < 8; i++) begin
      if (i == 0) begin ra = 32'h8000; rb = 32'h0001; rop = 2'b01; rc = 1'b0; end
      else begin ra = {16'd0, 16'($urandom)}; rb = {16'd0, 16'($urandom)}; rop = 2'($urandom); rc = 1'($urandom); end
      exp = model(16, ra, rb, rop, rc);
      @(negedge clk);
      p16_a = ra[15:0]; p16_b = rb[15:0]; p16_op = rop; p16_cin = rc; p16_in_valid = 1'b1;
      @(posedge clk); #1;
      p16_in_valid = 1'b0;
      lat = 0;
      while (!p16_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      got = {16'd0, p16_sum, p16_co, p16_ovf, p16_zero, p16_neg};
      checks++;
      if (lat !== 4) begin errors++; $display("FAIL w16_%0d_latency got=%0d want=4", i, lat); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL w16_%0d_result got=%h want=%h", i, got, exp); end
      if (i == 0) begin
        checks++;
        if (p16_sum !== 16'h7FFF || p16_ovf !== 1'b1 || p16_co !== 1'b1) begin
          errors++; $display("FAIL w16_corner got sum=%h ovf=%b co=%b want 7fff 1 1", p16_sum, p16_ovf, p16_co);
        end
      end
      handshake();
    end
    for (int i = 0; i < 8; i++) begin
      ra = {24'd0, 8'($urandom)}; rb = {24'd0, 8'($urandom)}; rop = 2'($urandom); rc = 1'($urandom);
      exp = model(8, ra, rb, rop, rc);
      @(negedge clk);
      p8_a = ra[7:0]; p8_b = rb[7:0]; p8_op = rop; p8_cin = rc; p8_in_valid = 1'b1;
      @(posedge clk); #1;
      p8_in_valid = 1'b0;
      lat = 0;
      while (!p8_out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
      got = {24'd0, p8_sum, p8_co, p8_ovf, p8_zero, p8_neg};
      checks++;
      if (lat !== 1) begin errors++; $display("FAIL w8_%0d_latency got=%0d want=1", i, lat); end
      checks++;
      if (got !== exp) begin errors++; $display("FAIL w8_%0d_result got=%h want=%h", i, got, exp); end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_backpressure();
    test_reset_mid_run();
    test_back_to_back();
    test_params();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
